alu_result_display: RTL and testbench

Downstream display stage for `fsm_alu`. It captures the 5-bit `result` and `cout` on each rising edge of the ALU's done indication and converts the value to two BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, two-digit, active-low seven-segment display on the lab board.

---
 rtl/alu_disp_pkg.sv | 35 +++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/alu_result_display.sv | 193 +++++++++++++++++++
 tb/tb_alu_result_display.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
// Shared types, constants and the double-dabble step helper for the ALU result display.
package alu_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_SHOW    = 2'd2
   } state_e;

   localparam int NUM_SHIFTS = 5;

   // Active-low segment codes, bit order g,f,e,d,c,b,a
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // One shift-add-3 iteration: returns {bcd, bin} after adjust and shift
   function automatic logic [12:0] dabble_step(input logic [7:0] bcd, input logic [4:0] bin);
      logic [7:0] adj;
      if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
      else                  adj[3:0] = bcd[3:0];
      if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
      else                  adj[7:4] = bcd[7:4];
      return {adj, bin} << 1;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder; 10..15 are blank.
module bcd_to_seg7
   import alu_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // digit lookup
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/alu_result_display.sv
// Captures the ALU result on done rising, converts it to BCD serially and drives a
// multiplexed two-digit display. Define LEADING_ZERO_BLANK_EN to darken a zero tens digit.
module alu_result_display
   import alu_disp_pkg::*;
#(
   parameter int REFRESH_CNT = 50000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       done,
   input  logic [4:0] result,
   input  logic       cout,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] an,
   output logic       busy,
   output logic       valid
);

   localparam int CW = $clog2(REFRESH_CNT);

   state_e          state_r, nxt_state_s;
   logic            done_q_r, start_s;
   logic [4:0]      bin_r, nxt_bin_s;
   logic [7:0]      bcd_r, nxt_bcd_s;
   logic [2:0]      cnt_r, nxt_cnt_s;
   logic            conv_cout_r, nxt_conv_cout_s;
   logic            pend_r, nxt_pend_s;
   logic [5:0]      pend_val_r, nxt_pend_val_s;
   logic [3:0]      tens_r, nxt_tens_s, ones_r, nxt_ones_s;
   logic            disp_cout_r, nxt_disp_cout_s;
   logic            valid_r, nxt_valid_s, busy_r, nxt_busy_s;
   logic [CW-1:0]   refresh_r, nxt_refresh_s;
   logic            sel_r, nxt_sel_s;
   logic [12:0]     step_s;
   logic [3:0]      digit_s;
   logic [6:0]      code_s, nxt_seg_s;
   logic [1:0]      nxt_an_s;
   logic            nxt_dp_s;

   assign start_s = done & ~done_q_r;
   assign step_s  = dabble_step(bcd_r, bin_r);

   // conversion FSM, pending restart and refresh counter next-state logic
   always_comb begin
      nxt_state_s     = state_r;
      nxt_bin_s       = bin_r;
      nxt_bcd_s       = bcd_r;
      nxt_cnt_s       = cnt_r;
      nxt_conv_cout_s = conv_cout_r;
      nxt_pend_s      = pend_r;
      nxt_pend_val_s  = pend_val_r;
      nxt_tens_s      = tens_r;
      nxt_ones_s      = ones_r;
      nxt_disp_cout_s = disp_cout_r;
      nxt_valid_s     = valid_r;
      nxt_busy_s      = busy_r;
      case (state_r)
         ST_IDLE, ST_SHOW: begin
            if (start_s) begin
               nxt_state_s     = ST_CONVERT;
               nxt_bin_s       = result;
               nxt_conv_cout_s = cout;
               nxt_bcd_s       = 8'd0;
               nxt_cnt_s       = 3'd0;
               nxt_busy_s      = 1'b1;
            end else begin
               nxt_busy_s      = 1'b0;
            end
         end
         ST_CONVERT: begin
            nxt_bcd_s = step_s[12:5];
            nxt_bin_s = step_s[4:0];
            nxt_cnt_s = cnt_r + 3'd1;
            if (start_s) begin
               nxt_pend_s     = 1'b1;
               nxt_pend_val_s = {cout, result};
            end else begin
               nxt_pend_s     = pend_r;
            end
            if (cnt_r == 3'(NUM_SHIFTS - 1)) begin
               nxt_tens_s      = step_s[12:9];
               nxt_ones_s      = step_s[8:5];
               nxt_disp_cout_s = conv_cout_r;
               nxt_valid_s     = 1'b1;
               nxt_bcd_s       = 8'd0;
               nxt_cnt_s       = 3'd0;
               // an edge landing on the final iteration is newer than any pending value
               if (start_s) begin
                  nxt_bin_s       = result;
                  nxt_conv_cout_s = cout;
                  nxt_pend_s      = 1'b0;
               end else if (pend_r) begin
                  nxt_bin_s       = pend_val_r[4:0];
                  nxt_conv_cout_s = pend_val_r[5];
                  nxt_pend_s      = 1'b0;
               end else begin
                  nxt_state_s     = ST_SHOW;
                  nxt_busy_s      = 1'b0;
               end
            end else begin
               nxt_valid_s = valid_r;
            end
         end
         default: begin
            nxt_state_s = ST_IDLE;
            nxt_busy_s  = 1'b0;
         end
      endcase
      if (refresh_r == CW'(REFRESH_CNT - 1)) begin
         nxt_refresh_s = '0;
         nxt_sel_s     = ~sel_r;
      end else begin
         nxt_refresh_s = refresh_r + CW'(1);
         nxt_sel_s     = sel_r;
      end
   end

   assign digit_s = nxt_sel_s ? nxt_tens_s : nxt_ones_s;

   bcd_to_seg7 u_dec (
      .bcd (digit_s),
      .seg (code_s)
   );

   // display drive computed from next-state values so outputs update with the digits
   always_comb begin
      nxt_seg_s = SEG_BLANK;
      nxt_an_s  = 2'b11;
      nxt_dp_s  = 1'b1;
      if (!nxt_valid_s) begin
         nxt_seg_s = SEG_BLANK;
      end else if (nxt_sel_s) begin
         nxt_seg_s = code_s;
`ifdef LEADING_ZERO_BLANK_EN
         nxt_an_s  = (nxt_tens_s == 4'd0) ? 2'b11 : 2'b01;
`else
         nxt_an_s  = 2'b01;
`endif
      end else begin
         nxt_seg_s = code_s;
         nxt_an_s  = 2'b10;
         nxt_dp_s  = ~nxt_disp_cout_s;
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         done_q_r    <= 1'b0;
         bin_r       <= 5'd0;
         bcd_r       <= 8'd0;
         cnt_r       <= 3'd0;
         conv_cout_r <= 1'b0;
         pend_r      <= 1'b0;
         pend_val_r  <= 6'd0;
         tens_r      <= 4'd0;
         ones_r      <= 4'd0;
         disp_cout_r <= 1'b0;
         valid_r     <= 1'b0;
         busy_r      <= 1'b0;
         refresh_r   <= '0;
         sel_r       <= 1'b0;
         seg         <= SEG_BLANK;
         an          <= 2'b11;
         dp          <= 1'b1;
      end else begin
         state_r     <= nxt_state_s;
         done_q_r    <= done;
         bin_r       <= nxt_bin_s;
         bcd_r       <= nxt_bcd_s;
         cnt_r       <= nxt_cnt_s;
         conv_cout_r <= nxt_conv_cout_s;
         pend_r      <= nxt_pend_s;
         pend_val_r  <= nxt_pend_val_s;
         tens_r      <= nxt_tens_s;
         ones_r      <= nxt_ones_s;
         disp_cout_r <= nxt_disp_cout_s;
         valid_r     <= nxt_valid_s;
         busy_r      <= nxt_busy_s;
         refresh_r   <= nxt_refresh_s;
         sel_r       <= nxt_sel_s;
         seg         <= nxt_seg_s;
         an          <= nxt_an_s;
         dp          <= nxt_dp_s;
      end
   end

   assign busy  = busy_r;
   assign valid = valid_r;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with a short refresh period.
module tb_alu_result_display;

   logic       clk = 1'b0;
   logic       reset, done, cout;
   logic [4:0] result;
   logic [6:0] seg;
   logic       dp, busy, valid;
   logic [1:0] an;
   int         total = 0;
   int         bad = 0;
   logic [6:0] o_seg, t_seg;
   logic       o_dp, t_dp, t_seen;

   always #5 clk = ~clk;

   alu_result_display #(.REFRESH_CNT(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .done   (done),
      .result (result),
      .cout   (cout),
      .seg    (seg),
      .dp     (dp),
      .an     (an),
      .busy   (busy),
      .valid  (valid)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // observe both digit slots over two full refresh periods
   task automatic capture();
      o_seg = 7'bx; o_dp = 1'bx; t_seg = 7'bx; t_dp = 1'bx; t_seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (an == 2'b10) begin o_seg = seg; o_dp = dp; end
         if (an == 2'b01) begin t_seg = seg; t_dp = dp; t_seen = 1'b1; end
      end
   endtask

   task automatic pulse(input logic [4:0] r, input logic c, output int cyc);
      @(negedge clk);
      result = r; cout = c; done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      int         cyc, nconv;
      logic       prev, lit, saw9, synced;
      logic [1:0] a0, exp_an;

      reset = 1'b1; done = 1'b0; result = 5'd0; cout = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("rst_seg", 8'(seg), 8'h7F);
      chk("rst_an", 8'(an), 8'h3);
      chk("rst_dp", 8'(dp), 8'h1);
      chk("rst_busy", 8'(busy), 8'h0);
      chk("rst_valid", 8'(valid), 8'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      chk("idle_an", 8'(an), 8'h3);
      chk("idle_seg", 8'(seg), 8'h7F);

      // 18 with carry: tens 1, ones 8, dp lit on ones only
      pulse(5'd18, 1'b1, cyc);
      chk("b18_busy_cycles", 8'(cyc), 8'd5);
      chk("b18_valid", 8'(valid), 8'h1);
      capture();
      chk("b18_ones", 8'(o_seg), 8'h00);
      chk("b18_tens", 8'(t_seg), 8'h79);
      chk("b18_ones_dp", 8'(o_dp), 8'h0);
      chk("b18_tens_dp", 8'(t_dp), 8'h1);

      // reset in the middle of a conversion
      @(negedge clk);
      result = 5'd5; cout = 1'b0; done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      chk("mid_busy", 8'(busy), 8'h1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_seg", 8'(seg), 8'h7F);
      chk("mid_rst_an", 8'(an), 8'h3);
      chk("mid_rst_dp", 8'(dp), 8'h1);
      chk("mid_rst_busy", 8'(busy), 8'h0);
      chk("mid_rst_valid", 8'(valid), 8'h0);
      @(negedge clk);
      reset = 1'b1;
      lit = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (an != 2'b11 || seg != 7'h7F) lit = 1'b1;
      end
      chk("post_rst_dark", 8'(lit), 8'h0);
      chk("post_rst_valid", 8'(valid), 8'h0);

      // zero value
      pulse(5'd0, 1'b0, cyc);
      chk("z_busy_cycles", 8'(cyc), 8'd5);
      capture();
      chk("z_ones", 8'(o_seg), 8'h40);
      chk("z_ones_dp", 8'(o_dp), 8'h1);
`ifdef LEADING_ZERO_BLANK_EN
      chk("z_tens_dark", 8'(t_seen), 8'h0);
`else
      chk("z_tens", 8'(t_seg), 8'h40);
`endif

      // 31 with done held for 10 cycles: a single conversion
      @(negedge clk);
      result = 5'd31; cout = 1'b0; done = 1'b1;
      nconv = 0; prev = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (busy && !prev) nconv++;
         prev = busy;
         if (i == 9) done = 1'b0;
      end
      chk("m31_conversions", 8'(nconv), 8'd1);
      chk("m31_busy", 8'(busy), 8'h0);
      capture();
      chk("m31_tens", 8'(t_seg), 8'h30);
      chk("m31_ones", 8'(o_seg), 8'h79);

      // refresh mux: 4 cycles per digit
      a0 = an; synced = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (an != a0) begin synced = 1'b1; break; end
      end
      chk("mux_sync", 8'(synced), 8'h1);
      a0 = an;
      chk("mux_first_an_legal", 8'(a0 == 2'b10 || a0 == 2'b01), 8'h1);
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         exp_an = (i < 4) ? a0 : ~a0;
         chk("mux_an", 8'(an), 8'(exp_an));
      end

      // second edge during conversion: 9 then 7, busy for 10 cycles
      @(negedge clk);
      result = 5'd9; cout = 1'b0; done = 1'b1;
      cyc = 0; saw9 = 1'b0;
      @(negedge clk);
      if (busy) cyc++;
      done = 1'b0;
      @(negedge clk);
      if (busy) cyc++;
      result = 5'd7; done = 1'b1;
      @(negedge clk);
      if (busy) cyc++;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
         if (an == 2'b10 && seg == 7'h10) saw9 = 1'b1;
      end
      chk("pend_busy_cycles", 8'(cyc), 8'd10);
      chk("pend_saw9", 8'(saw9), 8'h1);
      chk("pend_valid", 8'(valid), 8'h1);
      capture();
      chk("pend_ones7", 8'(o_seg), 8'h78);
`ifdef LEADING_ZERO_BLANK_EN
      chk("pend_tens_dark", 8'(t_seen), 8'h0);
`else
      chk("pend_tens0", 8'(t_seg), 8'h40);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
